pu_wb_arb: RTL

//  Write-back arbiter feeding the single PU register-file write port (wr/waddr/din).

---
 rtl/pu_wb_arb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pu_wb_arb.sv
// pu_wb_arb: write-back arbiter for the single PU register-file write port.
// ALU results take the direct path with priority. Load returns are buffered in a
// small in-order FIFO and drained when the ALU is idle, or forced after a run of
// blocked cycles. Hazard queries report registers whose write has not landed yet.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_valid/alu_waddr/alu_data     ALU result; alu_ready accepts it
//   ld_valid/ld_waddr/ld_data        load return; ld_ready means the FIFO has room
//   wr/waddr/din                     registered RF write port
//   q_addr0..2 / q_hit0..2           hazard query address / pending-write hit
module pu_wb_arb #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_NBITS = 5,
  parameter int unsigned FIFO_NBITS  = 2,
  parameter int unsigned STARVE_MAX  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [DEPTH_NBITS-1:0] alu_waddr,
  input  logic [WIDTH-1:0]       alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [DEPTH_NBITS-1:0] ld_waddr,
  input  logic [WIDTH-1:0]       ld_data,
  output logic                   ld_ready,
  output logic                   wr,
  output logic [DEPTH_NBITS-1:0] waddr,
  output logic [WIDTH-1:0]       din,
  input  logic [DEPTH_NBITS-1:0] q_addr0,
  input  logic [DEPTH_NBITS-1:0] q_addr1,
  input  logic [DEPTH_NBITS-1:0] q_addr2,
  output logic                   q_hit0,
  output logic                   q_hit1,
  output logic                   q_hit2
);

  localparam int unsigned FDEPTH = 1 << FIFO_NBITS;
  localparam int unsigned CNT_W  = FIFO_NBITS + 1;
  localparam int unsigned SC_W   = $clog2(STARVE_MAX + 1);

  // FIFO storage (no reset needed: validity comes from count/pointers)
  logic [DEPTH_NBITS-1:0] mem_waddr_q [FDEPTH];
  logic [WIDTH-1:0]       mem_data_q  [FDEPTH];

  logic [FIFO_NBITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_NBITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [SC_W-1:0]        starve_q, starve_d;
  logic                   force_q, force_d;
  logic                   wr_q, wr_d;
  logic [DEPTH_NBITS-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]       din_q, din_d;

  logic alu_fire, ld_push, pop, fifo_empty;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      force_q  <= 1'b0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      din_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      force_q  <= force_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
    end
  end

  // FIFO write; ld_push is already gated off during reset
  always_ff @(posedge clk) begin
    if (ld_push) begin
      mem_waddr_q[wr_ptr_q] <= ld_waddr;
      mem_data_q[wr_ptr_q]  <= ld_data;
    end
  end

  // Handshakes, pop decision, next state
  always_comb begin
    alu_ready  = !rst && !force_q;
    ld_ready   = !rst && (count_q != CNT_W'(FDEPTH));
    alu_fire   = alu_valid && alu_ready;
    ld_push    = ld_valid && ld_ready;
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty && !alu_fire;

    rd_ptr_d = rd_ptr_q + FIFO_NBITS'(pop);
    wr_ptr_d = wr_ptr_q + FIFO_NBITS'(ld_push);
    count_d  = count_q + CNT_W'(ld_push) - CNT_W'(pop);

    wr_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    if (alu_fire) begin
      wr_d    = 1'b1;
      waddr_d = alu_waddr;
      din_d   = alu_data;
    end else if (pop) begin
      wr_d    = 1'b1;
      waddr_d = mem_waddr_q[rd_ptr_q];
      din_d   = mem_data_q[rd_ptr_q];
    end

    // Non-empty and not popping means the ALU blocked the drain this cycle
    starve_d = '0;
    force_d  = 1'b0;
    if (!fifo_empty && !pop) begin
      if (starve_q == SC_W'(STARVE_MAX - 1)) begin
        force_d  = 1'b1;
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + SC_W'(1);
      end
    end
  end

  // Hazard query from registered state only
  always_comb begin
    logic [FIFO_NBITS-1:0] off;
    q_hit0 = wr_q && (waddr_q == q_addr0);
    q_hit1 = wr_q && (waddr_q == q_addr1);
    q_hit2 = wr_q && (waddr_q == q_addr2);
    for (int unsigned i = 0; i < FDEPTH; i++) begin
      off = FIFO_NBITS'(i) - rd_ptr_q;
      if (CNT_W'(off) < count_q) begin
        q_hit0 = q_hit0 || (mem_waddr_q[i] == q_addr0);
        q_hit1 = q_hit1 || (mem_waddr_q[i] == q_addr1);
        q_hit2 = q_hit2 || (mem_waddr_q[i] == q_addr2);
      end
    end
  end

  assign wr    = wr_q;
  assign waddr = waddr_q;
  assign din   = din_q;

endmodule
